stereo_addr_sequencer: RTL

STEREO_ADDR_SEQUENCER -- requirements
Module: stereo_addr_sequencer

---
 rtl/stereo_addr_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stereo_addr_sequencer.sv
// Line-buffer read address sequencer for a multi-pass stereo disparity engine.
// Optional macro STEREO_ADDR_CLAMP_EN: saturate right addresses at LAST instead of wrapping.
module stereo_addr_sequencer #(
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned PAD        = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned NUM_PIPES  = 4,
    parameter int unsigned NUM_PASSES = 16,
    localparam int unsigned PASS_W    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        read_start,
    input  logic                        hold,
    output logic                        read_enable,
    output logic [ADDR_W-1:0]           address_left,
    output logic [NUM_PIPES*ADDR_W-1:0] address_right,
    output logic [PASS_W-1:0]           pass_index,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned LAST  = LINE_WIDTH + PAD - 1;
    localparam int unsigned SUM_W = ADDR_W + 1;
    localparam int unsigned RA_W  = NUM_PIPES * ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [PASS_W-1:0]   r_pass;
    logic [PASS_W-1:0]   w_pass_next;
    logic [RA_W-1:0]     r_right;
    logic [RA_W-1:0]     w_right_next;
    logic                r_read_enable;
    logic                w_read_enable_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_done;
    logic                w_done_next;

    // Right address per pipe: left + pass*NUM_PIPES + k, formed one bit wider than the bus.
    function automatic logic [RA_W-1:0] right_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [PASS_W-1:0] p);
        logic [RA_W-1:0]  v;
        logic [SUM_W-1:0] s;
        v = '0;
        for (int k = 0; k < int'(NUM_PIPES); k++) begin
            s = SUM_W'(a) + SUM_W'(p) * SUM_W'(NUM_PIPES) + SUM_W'(k);
`ifdef STEREO_ADDR_CLAMP_EN
            v[k*ADDR_W +: ADDR_W] = (s > SUM_W'(LAST)) ? ADDR_W'(LAST) : ADDR_W'(s);
`else
            v[k*ADDR_W +: ADDR_W] = ADDR_W'(s);
`endif
        end
        return v;
    endfunction

    // Next state and next registered outputs.
    always_comb begin
        w_state_next       = r_state;
        w_addr_next        = r_addr;
        w_pass_next        = r_pass;
        w_read_enable_next = 1'b0;
        w_busy_next        = 1'b0;
        w_done_next        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (read_start) begin
                    w_state_next       = S_RUN;
                    w_addr_next        = '0;
                    w_pass_next        = '0;
                    w_read_enable_next = 1'b1;
                    w_busy_next        = 1'b1;
                end
            end
            S_RUN: begin
                w_busy_next = 1'b1;
                if (!hold) begin
                    if (r_addr == ADDR_W'(LAST)) begin
                        w_addr_next = '0;
                        if (r_pass == PASS_W'(NUM_PASSES - 1)) begin
                            w_state_next = S_DONE;
                            w_pass_next  = '0;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_pass_next        = r_pass + PASS_W'(1);
                            w_read_enable_next = 1'b1;
                        end
                    end else begin
                        w_addr_next        = r_addr + ADDR_W'(1);
                        w_read_enable_next = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_right_next = right_addr(w_addr_next, w_pass_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_pass        <= '0;
            r_right       <= right_addr('0, '0);
            r_read_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_pass        <= w_pass_next;
            r_right       <= w_right_next;
            r_read_enable <= w_read_enable_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
        end
    end

    assign read_enable   = r_read_enable;
    assign address_left  = r_addr;
    assign address_right = r_right;
    assign pass_index    = r_pass;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
